// File: rtl/fpcvt_pkg.sv
// Shared widths, packed-float layout and FSM states for the float/linear converters.
package fpcvt_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned OUT_W = 12;
  localparam int unsigned FP_W  = 1 + EXP_W + SIG_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fp_sm_to_tc.sv
// Combinational sign-magnitude to OUT_W-bit two's-complement conversion.
module fp_sm_to_tc
  import fpcvt_pkg::*;
(
  input  logic             sgn_i,
  input  logic [OUT_W-1:0] mag_i,
  output logic [OUT_W-1:0] tc_c_o
);

  // A zero magnitude negates to zero, so negative zero needs no special case.
  assign tc_c_o = sgn_i ? (~mag_i + OUT_W'(1)) : mag_i;

endmodule

// File: rtl/fp_expand.sv
// Iterative 8-bit float -> 12-bit linear expander, one shift per clock.
// Build option FPX_MIDPOINT_EN reconstructs the quantization-interval midpoint.
module fp_expand
  import fpcvt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  state_e           state_q;
  logic [OUT_W-1:0] mag_q;
  logic [EXP_W-1:0] cnt_q;
  logic             sgn_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [OUT_W-1:0] tc_d;
  logic             shift_in_d;
  fp_t              in_f;

  assign in_f      = fp_t'(in_data);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef FPX_MIDPOINT_EN
  // Shifting a 1 in on the first step adds 1<<(exp-1) once all exp shifts are done.
  logic first_q;
  assign shift_in_d = first_q;
`else
  assign shift_in_d = 1'b0;
`endif

  fp_sm_to_tc u_sm_to_tc (
    .sgn_i  (sgn_q),
    .mag_i  (mag_q),
    .tc_c_o (tc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FPX_MIDPOINT_EN
      first_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mag_q      <= OUT_W'(in_f.sig);
            cnt_q      <= in_f.exp;
            sgn_q      <= in_f.sign;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
`ifdef FPX_MIDPOINT_EN
            first_q    <= 1'b1;
`endif
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            mag_q   <= {mag_q[OUT_W-2:0], shift_in_d};
            cnt_q   <= cnt_q - EXP_W'(1);
`ifdef FPX_MIDPOINT_EN
            first_q <= 1'b0;
`endif
          end else begin
            out_data_q  <= tc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
